// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Holds the op encodings, the FSM state type and small op-decode helpers that the
// hazard unit also uses to decide whether an op will occupy the unit for many cycles.
package mdu_pkg;

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpDiv   = 3'd2,
    OpDivu  = 3'd3,
    OpMthi  = 3'd4,
    OpMtlo  = 3'd5
  } mdu_op_e;  // 6 and 7 are no-ops

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StDone
  } mdu_state_e;

  // Multi-cycle op: MULT/MULTU/DIV/DIVU all sit below 4.
  function automatic logic mdu_is_long(input logic [2:0] op);
    return op[2] == 1'b0;
  endfunction

  function automatic logic mdu_is_div(input logic [2:0] op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

  function automatic logic mdu_is_signed(input logic [2:0] op);
    return (op == OpMult) || (op == OpDiv);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration of the iterative multiply/divide datapath (combinational).
// Ports:
//   div_i  - 0: shift-add multiply step, 1: restoring divide step
//   acc_i  - 2*WIDTH+1 accumulator. Multiply: {carry, partial hi, multiplier/low}.
//            Divide: {remainder (WIDTH+1), dividend/quotient (WIDTH)}.
//   b_i    - multiplicand or divisor magnitude
//   acc_o  - accumulator after one step
module mdu_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               div_i,
  input  logic [2*WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH:0]   acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    // Multiply: add multiplicand into the upper half when the current multiplier bit is set.
    sum    = acc_i[2*WIDTH:WIDTH] + (acc_i[0] ? {1'b0, b_i} : '0);
    // Divide: shift the next dividend bit into the remainder before the trial subtract.
    rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, b_i};
    if (!div_i) begin
      acc_o = {1'b0, sum, acc_i[WIDTH-1:1]};
    end else if (rem_sh >= {1'b0, b_i}) begin
      acc_o = {diff, acc_i[WIDTH-2:0], 1'b1};
    end else begin
      acc_o = {rem_sh, acc_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Ports:
//   clk_i, rst_ni        - clock, asynchronous active-low reset
//   start_i, op_i        - issue strobe and op code (mdu_pkg encodings)
//   a_i, b_i             - rs / rt operands (a_i is the MTHI/MTLO source)
//   flush_i              - abort the in-flight multiply/divide
//   busy_o               - multiply/divide in progress (RUN or FIX)
//   done_o               - one-cycle pulse when HI/LO hold a new result
//   hi_o, lo_o           - HI and LO registers
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned AccW = 2 * WIDTH + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  mdu_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic             div_q, div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [AccW-1:0]    step_acc;
  logic               accept;
  logic               is_signed;
  logic               div_by_zero;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_raw, prod;
  logic [WIDTH-1:0]   quot, rem;

  mdu_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .div_i(div_q),
    .acc_i(acc_q),
    .b_i  (divisor_q),
    .acc_o(step_acc)
  );

  always_comb begin
    accept      = start_i && !flush_i && ((state_q == StIdle) || (state_q == StDone));
    is_signed   = mdu_is_signed(op_i);
    div_by_zero = mdu_is_div(op_i) && (b_i == '0);
    mag_a       = (is_signed && a_i[WIDTH-1]) ? -a_i : a_i;
    mag_b       = (is_signed && b_i[WIDTH-1]) ? -b_i : b_i;

    prod_raw = acc_q[2*WIDTH-1:0];
    prod     = neg_res_q ? -prod_raw : prod_raw;
    quot     = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem      = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    divisor_d = divisor_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          if (mdu_is_long(op_i)) begin
            state_d   = StRun;
            cnt_d     = CntMax;
            acc_d     = {{(WIDTH + 1){1'b0}}, mag_a};
            divisor_d = mag_b;
            div_d     = mdu_is_div(op_i);
            // Divide by zero leaves an all-ones quotient and |a| remainder; keeping the
            // quotient positive and giving the remainder a's sign yields lo='1, hi=a.
            neg_res_d = is_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]) && !div_by_zero;
            neg_rem_d = is_signed && a_i[WIDTH-1];
          end else if (op_i == OpMthi) begin
            hi_d = a_i;
          end else if (op_i == OpMtlo) begin
            lo_d = a_i;
          end
        end
      end
      StRun: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          acc_d = step_acc;
          if (cnt_q == '0) begin
            state_d = StFix;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      StFix: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          state_d = StDone;
          if (div_q) begin
            hi_d = rem;
            lo_d = quot;
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StRun) || (state_d == StFix);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      divisor_q <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      divisor_q <= divisor_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed scenarios plus randomized ops on a 32-bit
// and an 8-bit instance, checked against an arithmetic reference model.
module tb_mdu_hilo;

  logic clk = 1'b0;
  logic rst_n;

  logic        start32, flush32;
  logic [2:0]  op32;
  logic [31:0] a32, b32;
  logic        busy32, done32;
  logic [31:0] hi32, lo32;

  logic        start8, flush8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_hi32, exp_lo32;
  logic [31:0] exp_hi8, exp_lo8;

  mdu_hilo #(.WIDTH(32)) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start32), .op_i(op32), .a_i(a32), .b_i(b32),
    .flush_i(flush32), .busy_o(busy32), .done_o(done32), .hi_o(hi32), .lo_o(lo32)
  );

  mdu_hilo #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .op_i(op8), .a_i(a8), .b_i(b8),
    .flush_i(flush8), .busy_o(busy8), .done_o(done8), .hi_o(hi8), .lo_o(lo8)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic at width w, HI/LO updated in place.
  function automatic void model(input int w, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, inout logic [31:0] hi,
                                inout logic [31:0] lo);
    longint unsigned mask, ua, ub, p;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = longint'(ua);
    sb = longint'(ub);
    if (a[w-1]) sa = sa - longint'(mask) - 1;
    if (b[w-1]) sb = sb - longint'(mask) - 1;
    case (op)
      3'd0: begin p = longint'(sa * sb); lo = 32'(p & mask); hi = 32'((p >> w) & mask); end
      3'd1: begin p = ua * ub; lo = 32'(p & mask); hi = 32'((p >> w) & mask); end
      3'd2, 3'd3: begin
        if (ub == 0) begin
          lo = 32'(mask);
          hi = 32'(ua);
        end else if (op == 3'd2) begin
          q = sa / sb;
          r = sa % sb;
          lo = 32'(q & mask);
          hi = 32'(r & mask);
        end else begin
          lo = 32'((ua / ub) & mask);
          hi = 32'((ua % ub) & mask);
        end
      end
      3'd4: hi = 32'(ua);
      3'd5: lo = 32'(ua);
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start32 = 1'b1; op32 = op; a32 = a; b32 = b;
    tick();
    start32 = 1'b0;
  endtask

  task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    start8 = 1'b1; op8 = op; a8 = a; b8 = b;
    tick();
    start8 = 1'b0;
  endtask

  // Edges since the accepting edge until done is seen, and samples with busy high.
  task automatic wait32(output int edges, output int busy_n);
    edges = 0;
    busy_n = busy32 ? 1 : 0;
    while (!done32 && edges < 200) begin
      tick();
      edges++;
      if (busy32) busy_n++;
    end
  endtask

  task automatic wait8(output int edges, output int busy_n);
    edges = 0;
    busy_n = busy8 ? 1 : 0;
    while (!done8 && edges < 200) begin
      tick();
      edges++;
      if (busy8) busy_n++;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({busy32, done32, hi32, lo32} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset32: busy=%b done=%b hi=%h lo=%h, want all 0", busy32, done32, hi32, lo32);
    end
    n_checks++;
    if ({busy8, done8, hi8, lo8} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset8: busy=%b done=%b hi=%h lo=%h, want all 0", busy8, done8, hi8, lo8);
    end
  endtask

  task automatic test_mult();
    int e, bn;
    issue32(3'd0, 32'hFFFF_FFFD, 32'd5);
    wait32(e, bn);
    n_checks++;
    if (e !== 33) begin n_fail++; $display("FAIL mult_latency: got %0d want 33", e); end
    n_checks++;
    if (bn !== 33) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d want 33", bn); end
    n_checks++;
    if (hi32 !== 32'hFFFF_FFFF || lo32 !== 32'hFFFF_FFF1) begin
      n_fail++;
      $display("FAIL mult_result: hi=%h lo=%h want FFFFFFFF FFFFFFF1", hi32, lo32);
    end
    tick();
    n_checks++;
    if (done32 !== 1'b0 || busy32 !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b busy=%b want 0 0", done32, busy32);
    end
  endtask

  task automatic test_multu();
    int e, bn;
    issue32(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait32(e, bn);
    n_checks++;
    if (e !== 33 || hi32 !== 32'hFFFF_FFFE || lo32 !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL multu: edges=%0d hi=%h lo=%h want 33 FFFFFFFE 00000001", e, hi32, lo32);
    end
  endtask

  task automatic test_back_to_back();
    int e, bn;
    issue32(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait32(e, bn);
    n_checks++;
    if (e !== 33 || hi32 !== 32'hFFFF_FFFF || lo32 !== 32'hFFFF_FFFD) begin
      n_fail++;
      $display("FAIL div_signed: edges=%0d hi=%h lo=%h want 33 FFFFFFFF FFFFFFFD", e, hi32, lo32);
    end
    // Issue during the DONE cycle.
    issue32(3'd3, 32'd7, 32'd0);
    n_checks++;
    if (busy32 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_no_idle: busy=%b want 1", busy32);
    end
    wait32(e, bn);
    n_checks++;
    if (e !== 33 || hi32 !== 32'd7 || lo32 !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL divu_by_zero: edges=%0d hi=%h lo=%h want 33 00000007 FFFFFFFF", e, hi32, lo32);
    end
  endtask

  task automatic test_flush_mt();
    int done_seen;
    issue32(3'd4, 32'h0000_ABCD, 32'd0);
    n_checks++;
    if (hi32 !== 32'h0000_ABCD || busy32 !== 1'b0 || done32 !== 1'b0) begin
      n_fail++;
      $display("FAIL mthi: hi=%h busy=%b done=%b want 0000ABCD 0 0", hi32, busy32, done32);
    end
    issue32(3'd5, 32'h0000_1234, 32'd0);
    n_checks++;
    if (lo32 !== 32'h0000_1234 || busy32 !== 1'b0) begin
      n_fail++;
      $display("FAIL mtlo: lo=%h busy=%b want 00001234 0", lo32, busy32);
    end
    issue32(3'd0, 32'd2, 32'd3);
    repeat (9) tick();
    n_checks++;
    if (busy32 !== 1'b1) begin n_fail++; $display("FAIL flush_pre_busy: busy=%b want 1", busy32); end
    flush32 = 1'b1;
    tick();
    flush32 = 1'b0;
    n_checks++;
    if (busy32 !== 1'b0 || lo32 !== 32'h0000_1234 || hi32 !== 32'h0000_ABCD) begin
      n_fail++;
      $display("FAIL flush_abort: busy=%b hi=%h lo=%h want 0 0000ABCD 00001234", busy32, hi32, lo32);
    end
    done_seen = 0;
    repeat (40) begin
      tick();
      if (done32) done_seen++;
    end
    n_checks++;
    if (done_seen !== 0 || lo32 !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL flush_no_done: done pulses=%0d lo=%h want 0 00001234", done_seen, lo32);
    end
  endtask

  task automatic test_async_reset();
    int e, bn;
    issue32(3'd2, 32'd100, 32'd7);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy32, done32, hi32, lo32} !== 66'd0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h want all 0", busy32, done32, hi32, lo32);
    end
    #3 rst_n = 1'b1;
    tick();
    issue32(3'd0, 32'd4, 32'd4);
    wait32(e, bn);
    n_checks++;
    if (e !== 33 || lo32 !== 32'd16 || hi32 !== 32'd0) begin
      n_fail++;
      $display("FAIL post_reset_mult: edges=%0d hi=%h lo=%h want 33 0 16", e, hi32, lo32);
    end
    exp_hi32 = 32'd0;
    exp_lo32 = 32'd16;
  endtask

  task automatic test_narrow();
    int e, bn;
    issue8(3'd2, 8'h80, 8'hFF);
    wait8(e, bn);
    n_checks++;
    if (e !== 9 || bn !== 9 || lo8 !== 8'h80 || hi8 !== 8'h00) begin
      n_fail++;
      $display("FAIL narrow_overflow: edges=%0d busy=%0d hi=%h lo=%h want 9 9 00 80", e, bn, hi8, lo8);
    end
    exp_hi8 = 32'h00;
    exp_lo8 = 32'h80;
  endtask

  task automatic test_random32();
    int e, bn;
    logic [2:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      a = pick();
      b = pick();
      model(32, op, a, b, exp_hi32, exp_lo32);
      issue32(op, a, b);
      if (op < 3'd4) begin
        wait32(e, bn);
        n_checks++;
        if (e !== 33 || hi32 !== exp_hi32 || lo32 !== exp_lo32) begin
          n_fail++;
          $display("FAIL rand32 op=%0d a=%h b=%h: edges=%0d hi=%h lo=%h want 33 %h %h",
                   op, a, b, e, hi32, lo32, exp_hi32, exp_lo32);
        end
      end else begin
        n_checks++;
        if (busy32 !== 1'b0 || hi32 !== exp_hi32 || lo32 !== exp_lo32) begin
          n_fail++;
          $display("FAIL rand32_short op=%0d a=%h: busy=%b hi=%h lo=%h want 0 %h %h",
                   op, a, busy32, hi32, lo32, exp_hi32, exp_lo32);
        end
      end
    end
  endtask

  task automatic test_random8();
    int e, bn;
    logic [2:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      a = {24'd0, 8'($urandom)};
      b = {24'd0, 8'($urandom)};
      if ($urandom_range(0, 4) == 0) b = {24'd0, 8'($urandom_range(0, 1))};
      if ($urandom_range(0, 4) == 0) a = 32'h80;
      model(8, op, a, b, exp_hi8, exp_lo8);
      issue8(op, a[7:0], b[7:0]);
      if (op < 3'd4) begin
        wait8(e, bn);
        n_checks++;
        if (e !== 9 || {24'd0, hi8} !== exp_hi8 || {24'd0, lo8} !== exp_lo8) begin
          n_fail++;
          $display("FAIL rand8 op=%0d a=%h b=%h: edges=%0d hi=%h lo=%h want 9 %h %h",
                   op, a[7:0], b[7:0], e, hi8, lo8, exp_hi8[7:0], exp_lo8[7:0]);
        end
      end else begin
        n_checks++;
        if (busy8 !== 1'b0 || {24'd0, hi8} !== exp_hi8 || {24'd0, lo8} !== exp_lo8) begin
          n_fail++;
          $display("FAIL rand8_short op=%0d a=%h: busy=%b hi=%h lo=%h want 0 %h %h",
                   op, a[7:0], busy8, hi8, lo8, exp_hi8[7:0], exp_lo8[7:0]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start32 = 1'b0; flush32 = 1'b0; op32 = 3'd0; a32 = '0; b32 = '0;
    start8 = 1'b0; flush8 = 1'b0; op8 = 3'd0; a8 = '0; b8 = '0;
    exp_hi32 = '0; exp_lo32 = '0; exp_hi8 = '0; exp_lo8 = '0;
    #17 rst_n = 1'b1;
    tick();
    test_reset();
    test_mult();
    test_multu();
    test_back_to_back();
    test_flush_mt();
    test_async_reset();
    test_narrow();
    test_random32();
    test_random8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It sits beside the EX-stage ALU and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from ID/EX. While an operation is in flight it reports `busy` to the hazard unit, which stalls any MFHI/MFLO or new multiply/divide op. Width is generic, and it supports a flush abort for squashed instructions, which the single-cycle ALU cannot do.

## Interface
- `WIDTH`, default 32: operand, HI and LO width (≥4).
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `start` input 1: issue strobe from EX; sampled when `op`, `a` and `b` are valid.
- `op` input 3: operation code (see `mdu_pkg`).
- `a` input WIDTH: rs operand, or the source value for MTHI/MTLO.
- `b` input WIDTH: rt operand.
- `flush` input 1: abort the in-flight operation (EX flush or branch squash).
- `busy` output 1: operation in progress; HI/LO not yet valid.
- `done` output 1: one-cycle pulse; HI/LO hold the new result.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation
- **States:** IDLE, RUN, FIX, DONE.
- **Reset values:** state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, iteration counter 0.
- **Start acceptance:** `start` is accepted only in IDLE or DONE. When `start` is high in RUN or FIX it is ignored; the hazard unit prevents this case.
- **MTHI/MTLO:** single cycle. On the accepting edge `a` is written to `hi` or `lo`, and state stays or returns to IDLE. `busy` and `done` stay 0.
- **MULT/MULTU/DIV/DIVU, on the accepting edge:**
  - Capture operand magnitudes (absolute value for signed ops), the result sign flags, and a divide-by-zero flag.
  - Load counter = WIDTH-1 and go to RUN.
- **RUN:** one radix-2 step per cycle.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring step on the {remainder, quotient} register.
  - At counter 0, go to FIX.
- **FIX (one cycle):**
  - Apply two's-complement negation. The product is negated if the operand signs differ. The quotient is negated if the signs differ. The remainder takes the sign of the dividend.
  - Write results: multiply gives `hi`=upper WIDTH bits and `lo`=lower WIDTH bits; divide gives `lo`=quotient and `hi`=remainder.
  - Go to DONE.
- **Divide by zero:** `lo`=all ones and `hi`=`a` (raw, unsigned view). Same latency as a normal divide. No exception.
- **Signed overflow** (most-negative / −1): `lo`=most-negative value, `hi`=0 (the natural wrap result).
- **DONE:** `done`=1. Next state is IDLE, or RUN if a new multiply/divide `start` is present (back-to-back issue).
- **Flush:** `flush` in RUN or FIX returns to IDLE on the next edge. `hi` and `lo` are unchanged and `done` is not pulsed. `flush` in IDLE or DONE has no effect. `flush` and `start` on the same edge: `flush` wins and the start is dropped.
- **Asynchronous reset mid-operation:** immediate return to IDLE with all outputs at their reset values.
- **Arithmetic:** internal accumulators are 2·WIDTH+1 bits wide. All outputs are truncated to exactly WIDTH bits; no sign extension leaks out.

## Timing
- For a multiply/divide accepted at edge k:
  - `busy`=1 from after edge k until after edge k+WIDTH+1, covering RUN (WIDTH cycles) and FIX (1 cycle).
  - `hi`/`lo` update at edge k+WIDTH+1.
  - `done`=1 during the cycle after edge k+WIDTH+1. For WIDTH=32 this is 33 edges after issue.
- `busy` is a registered output, decoded from state. `done` is registered.
- MTHI/MTLO: result is visible in the cycle after the accepting edge.
- `hi`/`lo` are stable whenever `busy`=0.

## Structure
- `mdu_pkg` holds:
  - Op encodings: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6 and 7 are no-ops.
  - The state enum.
  - A `mdu_is_long(op)` helper function, also used by the hazard unit.
- Sub-module `mdu_step` (combinational): one radix-2 iteration for both multiply and divide. It is selected by a mode bit and parametrised by WIDTH.
- The top-level module owns the FSM, the counter, sign handling and the HI/LO registers.

## Test plan
- **MULT:** WIDTH=32, `a`=−3, `b`=5 → after 33 edges `done` pulses; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. `busy` is high for exactly 33 cycles.
- **MULTU:** `a`=`b`=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- **Signed divide, then back-to-back:** DIV `a`=−7, `b`=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Then in the DONE cycle issue DIVU `a`=7, `b`=0 → next result `lo`=0xFFFFFFFF, `hi`=7, with no IDLE cycle in between.
- **Flush and move-to:** MTLO 0x1234 → `lo`=0x1234 next cycle with `busy`=0. Then MULT 2×3 with `flush` asserted on the 10th RUN cycle → IDLE next edge, `lo` still 0x1234, `done` never pulses.
- **Reset:** `reset` driven low asynchronously mid-DIV → `busy`, `done`, `hi` and `lo` are 0 immediately. After release, MULT 4×4 → `lo`=16.
- **Narrow width:** WIDTH=8, DIV `a`=0x80, `b`=0xFF → `lo`=0x80, `hi`=0x00, with `done` 9 edges after issue.
